// File: rtl/combat_engine.sv
// combat_engine: enemy and bullet slot pools in polar coordinates.
// Spawn and fire requests arrive over valid/ready handshakes. Each tick walks
// every slot through EMOVE/BMOVE/BSCAN to move objects, resolve collisions,
// count breaches and accumulate a saturating score.
module combat_engine #(
    parameter int N_ENEMY  = 8,
    parameter int N_BULLET = 32,
    parameter int DIST_W   = 8,
    parameter int ANG_W    = 4,
    parameter int SCORE_W  = 17
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    output logic               busy,
    output logic               tick_done,
    input  logic               spawn_valid,
    output logic               spawn_ready,
    input  logic [2:0]         spawn_type,
    input  logic [ANG_W-1:0]   spawn_angle,
    input  logic               fire_valid,
    output logic               fire_ready,
    input  logic [1:0]         fire_type,
    input  logic [ANG_W-1:0]   fire_angle,
    output logic [SCORE_W-1:0] score,
    output logic               breach,
    input  logic               rd_obj,
    input  logic [5:0]         rd_idx,
    output logic               rd_active,
    output logic [DIST_W-1:0]  rd_dist,
    output logic [ANG_W-1:0]   rd_angle
);
    localparam int EI_W = $clog2(N_ENEMY);
    localparam int BI_W = $clog2(N_BULLET);
    localparam int DW1  = DIST_W + 1;
    localparam int SW1  = SCORE_W + 1;
    localparam logic [EI_W-1:0]    E_LAST    = EI_W'(N_ENEMY - 1);
    localparam logic [BI_W-1:0]    B_LAST    = BI_W'(N_BULLET - 1);
    localparam logic [DIST_W-1:0]  MAX_DIST  = '1;
    localparam logic [SCORE_W-1:0] MAX_SCORE = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_FIRE, S_EMOVE, S_BMOVE, S_BSCAN, S_DONE
    } state_t;

    // Enemy type tables: health, speed, kill score
    function automatic logic [3:0] f_e_hp(input logic [2:0] t);
        case (t)
            3'd0:    return 4'd6;
            3'd1:    return 4'd3;
            3'd2:    return 4'd2;
            3'd3:    return 4'd9;
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic [2:0] f_e_spd(input logic [2:0] t);
        case (t)
            3'd0:    return 3'd3;
            3'd1:    return 3'd4;
            3'd2:    return 3'd5;
            3'd3:    return 3'd2;
            default: return 3'd1;
        endcase
    endfunction

    function automatic logic [3:0] f_e_kill(input logic [2:0] t);
        case (t)
            3'd0:    return 4'd6;
            3'd1:    return 4'd3;
            3'd2:    return 4'd2;
            3'd3:    return 4'd9;
            default: return 4'd5;
        endcase
    endfunction

    // Bullet type tables: speed, damage, pellet count
    function automatic logic [2:0] f_b_spd(input logic [1:0] t);
        case (t)
            2'd0:    return 3'd7;
            2'd1:    return 3'd5;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] f_b_dmg(input logic [1:0] t);
        case (t)
            2'd0:    return 4'd2;
            2'd1:    return 4'd3;
            default: return 4'd9;
        endcase
    endfunction

    function automatic logic [2:0] f_b_pel(input logic [1:0] t);
        case (t)
            2'd0:    return 3'd5;
            2'd1:    return 3'd3;
            default: return 3'd1;
        endcase
    endfunction

    // Spread offsets +2,-2,+1,-1,0; a type with P pellets starts at index 5-P
    function automatic logic [ANG_W-1:0] f_off(input logic [2:0] k);
        case (k)
            3'd0:    return ANG_W'(2);
            3'd1:    return ANG_W'((2 ** ANG_W) - 2);
            3'd2:    return ANG_W'(1);
            3'd3:    return '1;
            default: return '0;
        endcase
    endfunction

    state_t r_state, w_state_nxt;

    logic [N_ENEMY-1:0]  r_e_act;
    logic [DIST_W-1:0]   r_e_dist [N_ENEMY];
    logic [ANG_W-1:0]    r_e_ang  [N_ENEMY];
    logic [3:0]          r_e_hp   [N_ENEMY];
    logic [2:0]          r_e_type [N_ENEMY];

    logic [N_BULLET-1:0] r_b_act;
    logic [DIST_W-1:0]   r_b_dist [N_BULLET];
    logic [ANG_W-1:0]    r_b_ang  [N_BULLET];
    logic [1:0]          r_b_type [N_BULLET];

    logic [EI_W-1:0]     r_ei, r_sj;
    logic [BI_W-1:0]     r_bi;
    logic [2:0]          r_fk;
    logic [ANG_W-1:0]    r_f_ang;
    logic [1:0]          r_f_type;
    logic [SCORE_W-1:0]  r_score;

    logic                w_e_free, w_b_free, w_b_free2;
    logic [EI_W-1:0]     w_e_fidx;
    logic [BI_W-1:0]     w_b_fidx;
    logic                w_e_gone, w_b_ovf, w_hit, w_kill;
    logic [DW1-1:0]      w_b_sum;
    logic [3:0]          w_dmg;
    logic [SW1-1:0]      w_score_sum;
    logic                w_spawn_go, w_fire_go, w_tick_go;

    // Lowest free enemy slot
    always_comb begin
        w_e_free = 1'b0;
        w_e_fidx = '0;
        for (int i = N_ENEMY - 1; i >= 0; i--) begin
            if (!r_e_act[i]) begin
                w_e_free = 1'b1;
                w_e_fidx = EI_W'(i);
            end
        end
    end

    // Lowest free bullet slot, plus whether a second free slot exists
    always_comb begin
        w_b_free  = 1'b0;
        w_b_free2 = 1'b0;
        w_b_fidx  = '0;
        for (int i = N_BULLET - 1; i >= 0; i--) begin
            if (!r_b_act[i]) begin
                if (w_b_free) w_b_free2 = 1'b1;
                w_b_free = 1'b1;
                w_b_fidx = BI_W'(i);
            end
        end
    end

    // Per-cycle slot views for the move and scan states
    always_comb begin
        w_e_gone    = r_e_act[r_ei] &&
                      (r_e_dist[r_ei] <= DIST_W'(f_e_spd(r_e_type[r_ei])));
        w_b_sum     = {1'b0, r_b_dist[r_bi]} + DW1'(f_b_spd(r_b_type[r_bi]));
        w_b_ovf     = w_b_sum[DIST_W];
        w_hit       = r_e_act[r_sj] && (r_e_ang[r_sj] == r_b_ang[r_bi]) &&
                      (r_b_dist[r_bi] >= r_e_dist[r_sj]);
        w_dmg       = f_b_dmg(r_b_type[r_bi]);
        w_kill      = (w_dmg >= r_e_hp[r_sj]);
        w_score_sum = {1'b0, r_score} + SW1'(f_e_kill(r_e_type[r_sj]));
    end

    assign busy        = (r_state != S_IDLE);
    assign tick_done   = (r_state == S_DONE);
    assign breach      = (r_state == S_EMOVE) && w_e_gone;
    assign spawn_ready = rst_n && (r_state == S_IDLE) && !tick && w_e_free;
    assign fire_ready  = rst_n && (r_state == S_IDLE) && !tick && !spawn_valid && w_b_free;
    assign score       = r_score;

    assign w_tick_go  = (r_state == S_IDLE) && tick;
    assign w_spawn_go = spawn_valid && spawn_ready;
    assign w_fire_go  = fire_valid && fire_ready;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_tick_go)      w_state_nxt = S_EMOVE;
                else if (w_fire_go) w_state_nxt = S_FIRE;
            end
            S_FIRE: begin
                if (!w_b_free || r_fk == 3'd4 || !w_b_free2) w_state_nxt = S_IDLE;
            end
            S_EMOVE: begin
                if (r_ei == E_LAST) w_state_nxt = S_BMOVE;
            end
            S_BMOVE: begin
                if (r_b_act[r_bi] && !w_b_ovf) w_state_nxt = S_BSCAN;
                else if (r_bi == B_LAST)       w_state_nxt = S_DONE;
            end
            S_BSCAN: begin
                if (w_hit || r_sj == E_LAST)
                    w_state_nxt = (r_bi == B_LAST) ? S_DONE : S_BMOVE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Slot pools, walk indices, fire latch and score
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e_act  <= '0;
            r_b_act  <= '0;
            for (int i = 0; i < N_ENEMY; i++) begin
                r_e_dist[i] <= '0;
                r_e_ang[i]  <= '0;
                r_e_hp[i]   <= '0;
                r_e_type[i] <= '0;
            end
            for (int i = 0; i < N_BULLET; i++) begin
                r_b_dist[i] <= '0;
                r_b_ang[i]  <= '0;
                r_b_type[i] <= '0;
            end
            r_ei     <= '0;
            r_sj     <= '0;
            r_bi     <= '0;
            r_fk     <= '0;
            r_f_ang  <= '0;
            r_f_type <= '0;
            r_score  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_tick_go) begin
                        r_ei <= '0;
                    end else if (w_spawn_go) begin
                        r_e_act[w_e_fidx]  <= 1'b1;
                        r_e_dist[w_e_fidx] <= MAX_DIST;
                        r_e_ang[w_e_fidx]  <= spawn_angle;
                        r_e_hp[w_e_fidx]   <= f_e_hp(spawn_type);
                        r_e_type[w_e_fidx] <= spawn_type;
                    end else if (w_fire_go) begin
                        r_f_ang  <= fire_angle;
                        r_f_type <= fire_type;
                        r_fk     <= 3'd5 - f_b_pel(fire_type);
                    end
                end
                S_FIRE: begin
                    if (w_b_free) begin
                        r_b_act[w_b_fidx]  <= 1'b1;
                        r_b_dist[w_b_fidx] <= '0;
                        r_b_ang[w_b_fidx]  <= r_f_ang + f_off(r_fk);
                        r_b_type[w_b_fidx] <= r_f_type;
                    end
                    r_fk <= r_fk + 3'd1;
                end
                S_EMOVE: begin
                    if (w_e_gone)
                        r_e_act[r_ei] <= 1'b0;
                    else if (r_e_act[r_ei])
                        r_e_dist[r_ei] <= r_e_dist[r_ei] - DIST_W'(f_e_spd(r_e_type[r_ei]));
                    r_ei <= r_ei + EI_W'(1);
                    if (r_ei == E_LAST) r_bi <= '0;
                end
                S_BMOVE: begin
                    if (r_b_act[r_bi] && !w_b_ovf) begin
                        r_b_dist[r_bi] <= w_b_sum[DIST_W-1:0];
                        r_sj <= '0;
                    end else begin
                        if (r_b_act[r_bi]) r_b_act[r_bi] <= 1'b0;
                        r_bi <= r_bi + BI_W'(1);
                    end
                end
                S_BSCAN: begin
                    if (w_hit) begin
                        r_b_act[r_bi] <= 1'b0;
                        if (w_kill) begin
                            r_e_act[r_sj] <= 1'b0;
                            r_score <= w_score_sum[SCORE_W] ? MAX_SCORE : w_score_sum[SCORE_W-1:0];
                        end else begin
                            r_e_hp[r_sj] <= r_e_hp[r_sj] - w_dmg;
                        end
                    end
                    if (w_hit || r_sj == E_LAST) r_bi <= r_bi + BI_W'(1);
                    else                         r_sj <= r_sj + EI_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Renderer read port; out-of-range indices read as an empty slot
    always_comb begin
        rd_active = 1'b0;
        rd_dist   = '0;
        rd_angle  = '0;
        if (!rd_obj) begin
            if (int'(rd_idx) < N_ENEMY) begin
                rd_active = r_e_act[rd_idx[EI_W-1:0]];
                rd_dist   = r_e_dist[rd_idx[EI_W-1:0]];
                rd_angle  = r_e_ang[rd_idx[EI_W-1:0]];
            end
        end else begin
            if (int'(rd_idx) < N_BULLET) begin
                rd_active = r_b_act[rd_idx[BI_W-1:0]];
                rd_dist   = r_b_dist[rd_idx[BI_W-1:0]];
                rd_angle  = r_b_ang[rd_idx[BI_W-1:0]];
            end
        end
    end

endmodule

// File: doc/combat_engine.md
Name: combat_engine

Overview:
Sequential successor to the combinational enemy/bullet update functions. It holds parametrised enemy and bullet slot pools in polar coordinates (distance, angle) and accepts spawn and fire requests over valid/ready handshakes. On each game tick it walks every slot through a small FSM to move objects, resolve angle-matched collisions, count breaches and accumulate score. It sits between the input/level controller and the renderer; the renderer reads slot state through a combinational read port.

Parameters:
N_ENEMY, 8, enemy slot count (2..16)
N_BULLET, 32, bullet slot count (2..64)
DIST_W, 8, distance width; MAX_DIST = 2^DIST_W-1
ANG_W, 4, angle width; angles wrap modulo 2^ANG_W
SCORE_W, 17, score width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
tick  in  1  start one update pass; honoured only in IDLE
busy  out  1  high in any non-IDLE state
tick_done  out  1  one-cycle pulse when an update pass completes
spawn_valid  in  1  enemy spawn request
spawn_ready  out  1  IDLE & ~tick & any enemy slot free
spawn_type  in  3  enemy type
spawn_angle  in  ANG_W  enemy angle
fire_valid  in  1  fire request
fire_ready  out  1  IDLE & ~tick & ~spawn_valid & any bullet slot free
fire_type  in  2  bullet type
fire_angle  in  ANG_W  aim angle
score  out  SCORE_W  accumulated score, saturating
breach  out  1  one-cycle pulse when an enemy reaches the centre
rd_obj  in  1  0 = enemy pool, 1 = bullet pool
rd_idx  in  6  slot index; out of range reads as inactive
rd_active  out  1  combinational slot active flag
rd_dist  out  DIST_W  combinational slot distance
rd_angle  out  ANG_W  combinational slot angle

Behaviour:
- Reset (asynchronous, mid-operation included): all slots inactive with zero fields, score=0, FSM=IDLE. busy, tick_done, breach, spawn_ready and fire_ready are 0 while rst_n is low.
- Tables:
  - Enemy health/speed/kill score by type: 0: 6/3/6, 1: 3/4/3, 2: 2/5/2, 3: 9/2/9, 4-7: 15/1/5.
  - Bullet speed/damage/pellets by type: 0: 7/2/5, 1: 5/3/3, 2 and 3: 4/9/1.
- Priority in IDLE: tick > spawn > fire. Ready outputs depend combinationally on tick and spawn_valid as listed under Ports.
- Spawn: on a spawn handshake, the lowest free enemy slot gets dist=MAX_DIST, the type's health, active=1. Takes one cycle; the FSM stays in IDLE.
- Fire: on a fire handshake, enter FIRE. Each FIRE cycle fills the lowest free bullet slot with dist=0, the bullet type, and angle = fire_angle + offset (mod 2^ANG_W).
  - Offset sequence: +2, -2, +1, -1, 0, taking the last P entries, where P is the type's pellet count.
  - Return to IDLE when all pellets are placed or no slot is free; unplaced pellets are dropped silently.
  - fire_angle and fire_type are latched at the handshake.
- Tick pass, FSM sequence IDLE -> EMOVE -> BMOVE -> (BSCAN) -> DONE -> IDLE:
  - EMOVE: one enemy per cycle, index 0..N_ENEMY-1. If active and dist <= speed: deactivate, pulse breach, no score. Otherwise dist -= speed.
  - BMOVE: one bullet per cycle.
    - Inactive slot: advance to the next slot.
    - Active with dist + speed > MAX_DIST: deactivate, advance.
    - Otherwise: dist += speed, then go to BSCAN with j=0.
  - BSCAN: one enemy per cycle. A hit is enemy j active, angle equal to the bullet angle, and bullet dist >= enemy dist.
    - On a hit: bullet deactivated and the scan ends.
    - If damage >= health: enemy deactivated, score += kill score, saturating at 2^SCORE_W-1. Otherwise health -= damage.
    - No hit after j=N_ENEMY-1: return to BMOVE for the next bullet.
  - DONE: pulse tick_done for one cycle, then IDLE.
  - Deaths take effect immediately, so later bullets in the same pass see the updated enemy state.
- Latency: N_ENEMY + N_BULLET + (BSCAN cycles) + 1 cycles from the tick acceptance edge to tick_done. Worst case N_ENEMY + N_BULLET*(1+N_ENEMY) + 1.
- tick, spawn_valid and fire_valid asserted while busy are ignored; requesters hold valid until ready.
- Multiple breaches within one pass give separate pulses on separate EMOVE cycles.
- Arithmetic: no wrap on distance; enemy subtraction and bullet addition are guarded as above.

Test Plan:
- Reset, then spawn type 0 at angle 5 -> 1 cycle later rd enemy 0: active=1, dist=255; after 1 tick: dist=252, tick_done exactly 8+32+1=41 cycles after acceptance.
- Spawn type 2 at angle 3; fire type 2 at angle 3; tick x3 -> 3rd tick: bullet dist 12 >= enemy dist 255-15=240 fails. Pre-set case with enemy at dist 4, bullet dist 4 at angle 3 -> enemy killed, score=2, bullet inactive.
- Fire type 0 at angle 15 with 3 free bullet slots -> slots hold angles 1, 13, 0; fire returns to IDLE after 3 FIRE cycles; fire_ready=0 afterwards.
- Enemy type 4 at dist 1, tick -> breach pulses once, enemy inactive, score unchanged.
- Assert tick and spawn_valid together in IDLE -> spawn_ready=0, pass starts; spawn accepted in the first IDLE cycle after tick_done.
- Drop rst_n during BSCAN -> all outputs and slots zero immediately, busy=0; a new tick after release runs a full pass.
